// File: rtl/loop_cnt16.sv
// Two-level loop counter: the inner count reloads from a shadow register on expiry,
// and the outer count decrements once per completed inner pass.
//   state    | meaning
//   S_IDLE   | waiting for loads / start
//   S_INNER  | inner count decrements on step
//   S_RELOAD | one cycle: outer decrement, inner reload or finish
module loop_cnt16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             icount_ld,
  input  logic [WIDTH-1:0] icount_d,
  input  logic             ocount_ld,
  input  logic [WIDTH-1:0] ocount_d,
  input  logic             start,
  input  logic             step,
  input  logic             abort,
  output logic [WIDTH-1:0] icount,
  output logic [WIDTH-1:0] ocount,
  output logic             izero,
  output logic             ozero,
  output logic             busy,
  output logic             inner_done,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INNER  = 2'd1,
    S_RELOAD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_icount, w_icount_nxt;
  logic [WIDTH-1:0] r_ireload, w_ireload_nxt;
  logic [WIDTH-1:0] r_ocount, w_ocount_nxt;
  logic             r_inner_done, w_inner_done_nxt;
  logic             r_done, w_done_nxt;
  logic             w_izero, w_ozero, w_load;

  assign w_izero = (r_icount == '0);
  assign w_ozero = (r_ocount == '0);
  assign w_load  = icount_ld | ocount_ld;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      r_state      <= S_IDLE;
      r_icount     <= '0;
      r_ireload    <= '0;
      r_ocount     <= '0;
      r_inner_done <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_icount     <= w_icount_nxt;
      r_ireload    <= w_ireload_nxt;
      r_ocount     <= w_ocount_nxt;
      r_inner_done <= w_inner_done_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_icount_nxt     = r_icount;
    w_ireload_nxt    = r_ireload;
    w_ocount_nxt     = r_ocount;
    w_inner_done_nxt = 1'b0;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (icount_ld) begin
          w_icount_nxt  = icount_d;
          w_ireload_nxt = icount_d;
        end
        if (ocount_ld) begin
          w_ocount_nxt = ocount_d;
        end
        // A start coinciding with a load is dropped so it never sees stale counts.
        if (start && !w_load) begin
          if (w_izero || w_ozero) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_INNER;
          end
        end
      end
      S_INNER: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (step && !w_izero) begin
          w_icount_nxt = r_icount - ONE;
          if (r_icount == ONE) begin
            w_inner_done_nxt = 1'b1;
            w_state_nxt      = S_RELOAD;
          end
        end
      end
      S_RELOAD: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_ocount <= ONE) begin
          w_ocount_nxt = '0;
          w_done_nxt   = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_ocount_nxt = r_ocount - ONE;
          w_icount_nxt = r_ireload;
          w_state_nxt  = S_INNER;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign icount     = r_icount;
  assign ocount     = r_ocount;
  assign izero      = w_izero;
  assign ozero      = w_ozero;
  assign busy       = (r_state != S_IDLE);
  assign inner_done = r_inner_done;
  assign done       = r_done;

endmodule

// File: doc/loop_cnt16.md
Name: loop_cnt16

Overview:
- Two-level loop counter for the blitter/object-processor datapath in Tom.
- A 16-bit inner count is reloaded from a shadow register each time it expires.
- A 16-bit outer count decrements once per completed inner pass.
- Provides registered counts, zero flags and completion strobes to the downstream zero-detect and sequencing logic.

Parameters:
- WIDTH, 16, width of the inner and outer counters and load buses.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- resetl  input  1  asynchronous active-low reset
- icount_ld  input  1  load strobe for inner count and inner reload shadow
- icount_d  input  WIDTH  inner load value
- ocount_ld  input  1  load strobe for outer count
- ocount_d  input  WIDTH  outer load value
- start  input  1  begin loop sequence (single-cycle strobe)
- step  input  1  decrement request for the inner count
- abort  input  1  cancel the sequence in progress
- icount  output  WIDTH  current inner count (registered)
- ocount  output  WIDTH  current outer count (registered)
- izero  output  1  icount == 0
- ozero  output  1  ocount == 0
- busy  output  1  sequence in progress
- inner_done  output  1  one-cycle pulse when an inner pass completes
- done  output  1  one-cycle pulse when the whole sequence completes

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (resetl).
- Reset values: icount=0, ireload=0, ocount=0, state=IDLE, busy=0, inner_done=0, done=0. izero and ozero therefore read 1.
- izero and ozero are combinational from the count registers. busy = (state != IDLE).
- States: IDLE, INNER, RELOAD.
- IDLE:
  - icount_ld writes icount_d to both icount and ireload.
  - ocount_ld writes ocount_d to ocount.
  - Both loads may occur in the same cycle.
  - start while icount_ld or ocount_ld is asserted is ignored.
  - start with icount==0 or ocount==0 produces a done pulse in the next cycle; state stays IDLE and counts are unchanged.
  - Otherwise start moves the block to INNER; busy=1 from the next cycle.
- INNER:
  - step decrements icount by 1.
  - step with icount==1: icount becomes 0, inner_done pulses in the next cycle, next state is RELOAD.
  - Without step, all state holds.
- RELOAD (exactly one cycle; step ignored):
  - ocount decrements by 1.
  - If ocount was 1: ocount becomes 0, done pulses in the next cycle, icount stays 0, next state is IDLE.
  - Otherwise icount is set to ireload and the next state is INNER.
- Completion: done coincides with the first cycle busy=0.
- Latency: every step produces an icount change visible 1 cycle later. One inner pass of N steps plus the RELOAD cycle occupies N+1 step-cycles minimum. Total minimum length is M*(N+1) cycles from entering INNER.
- Loads while busy (icount_ld, ocount_ld) are ignored. start while busy is ignored.
- abort:
  - Return to IDLE next cycle from any state, with counts frozen at their current values. No done or inner_done pulse.
  - abort has priority over step and RELOAD actions in the same cycle.
  - abort in IDLE has no effect.
- No wrap-around: icount never decrements below 0 and ocount never decrements below 0.
- Asynchronous reset mid-sequence clears all registers immediately. Pulses are deasserted and no done is issued.
- Arithmetic is unsigned modulo 2^WIDTH. The load value 0xFFFF is a legal count of 65535.

Test Plan:
- Reset, then release → icount=0, ocount=0, izero=1, ozero=1, busy=0, no pulses.
- Load icount=3, ocount=2, start, step held high every cycle:
  - icount sequence 3,2,1,0, then RELOAD gives ocount 2→1 and icount=3.
  - Second pass gives icount 3,2,1,0 and ocount 1→0.
  - inner_done pulses twice; done pulses once, in the cycle busy falls. Total 8 cycles in INNER/RELOAD.
- Load icount=0, ocount=5, start → done pulses next cycle, busy never rises, counts unchanged.
- Load icount=4, ocount=1, start, step only on alternate cycles → icount decrements only on step cycles; done after 8 INNER cycles plus 1 RELOAD.
- Load icount=10, ocount=3, start, 4 steps, abort → busy=0 next cycle, icount=6, ocount=3, no done. A subsequent start resumes from icount=6.
- Load icount=0xFFFF, ocount=1 with icount_ld and start asserted in the same cycle → start ignored, busy=0. start next cycle → busy=1, and the first step gives icount=0xFFFE.
